message_stitcher: RTL and testbench

- Narrow-to-wide counterpart of the message slicing path.
- Accepts a stream of WIDTH-bit words, each marked by a single-cycle in_nd pulse, and packs each group of N_SLICES words into one WIDTH*N_SLICES word.
- Queues completed wide words in an internal FIFO and emits them using toggle signalling: each new word is flagged by out_nd changing level.
- Output is paced so that no more than one toggle occurs per MIN_GAP cycles, which lets a downstream slicer drain between words.

---
 rtl/message_pkg.sv | 17 +
 rtl/message_fifo.sv | 52 +++++
 rtl/message_stitcher.sv | 118 +++++++++++
 tb/tb_message_stitcher.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/message_pkg.sv
// Definitions shared by the message slicer and stitcher: slot ordering and toggle handshake.
// Pure declarations, no logic; out_nd idles at TOGGLE_RESET_LEVEL and flips once per word.
package message_pkg;

  localparam logic TOGGLE_RESET_LEVEL = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } pace_state_e;

  // The k-th narrow word of a group lives in slot n_slices-1-k (top slice travels first).
  function automatic int unsigned slot_idx(input int unsigned n_slices, input int unsigned k);
    return n_slices - 1 - k;
  endfunction

endpackage

// File: rtl/message_fifo.sv
// Single-clock FIFO with combinational head; push visible to pop the cycle after it lands.
// A push while full is ignored unless a pop happens in the same cycle; pop on empty is ignored.
module message_fifo #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int PW = LOG_DEPTH + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                   (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
  assign pop_dat = mem_q[rd_ptr_q[LOG_DEPTH-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[LOG_DEPTH-1:0]] <= push_dat;
  end

endmodule

// File: rtl/message_stitcher.sv
// Packs N_SLICES narrow words into one wide word, queues it, and emits it as an out_nd toggle.
// Toggle one cycle after the completing word at best, then at most one per MIN_GAP; overflow drops and sets error.
module message_stitcher
  import message_pkg::*;
#(
  parameter int N_SLICES       = 2,
  parameter int WIDTH          = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int LOG_FIFO_DEPTH = 3,
  parameter int MIN_GAP        = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_nd,
  input  logic                      flush,
  output logic [WIDTH*N_SLICES-1:0] out_data,
  output logic                      out_nd,
  output logic                      error
);

  localparam int OW = WIDTH * N_SLICES;
  localparam int CW = $clog2(N_SLICES);
  localparam int GW = $clog2(MIN_GAP + 1);

  logic [OW-1:0] data_q, data_d, word_w;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_w, push, pop;
  logic          error_q, error_d;

  logic [OW-1:0] fifo_dat;
  logic          fifo_full, fifo_empty;

  pace_state_e   state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic          out_nd_q, out_nd_d;

  // Unwritten slots stay zero because the accumulator is cleared on every push.
  always_comb begin
    word_w = data_q;
    if (in_nd) word_w[slot_idx(N_SLICES, 32'(cnt_q))*WIDTH +: WIDTH] = in_data;
    last_w = in_nd && (cnt_q == CW'(N_SLICES - 1));
    push   = last_w || (flush && (in_nd || (cnt_q != '0)));
    if (push) begin
      cnt_d  = '0;
      data_d = '0;
    end else begin
      cnt_d  = cnt_q + CW'(in_nd);
      data_d = word_w;
    end
    error_d = error_q | (push && fifo_full && !pop);
  end

  message_fifo #(
    .WIDTH    (OW),
    .DEPTH    (FIFO_DEPTH),
    .LOG_DEPTH(LOG_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_dat(word_w),
    .pop     (pop),
    .pop_dat (fifo_dat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    out_data_d = out_data_q;
    out_nd_d   = out_nd_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          out_data_d = fifo_dat;
          out_nd_d   = ~out_nd_q;
          gap_d      = GW'(MIN_GAP - 1);
          if (MIN_GAP > 1) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q <= GW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      cnt_q      <= '0;
      error_q    <= 1'b0;
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      out_data_q <= '0;
      out_nd_q   <= TOGGLE_RESET_LEVEL;
    end else begin
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      error_q    <= error_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      out_data_q <= out_data_d;
      out_nd_q   <= out_nd_d;
    end
  end

  assign out_data = out_data_q;
  assign out_nd   = out_nd_q;
  assign error    = error_q;

endmodule

// File: tb/tb_message_stitcher.sv
// Scoreboard bench for message_stitcher (N_SLICES=2, WIDTH=32, FIFO_DEPTH=8, MIN_GAP=2).
module tb_message_stitcher;

  localparam int W       = 32;
  localparam int N       = 2;
  localparam int OW      = W * N;
  localparam int MIN_GAP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_nd = 1'b0;
  logic          flush = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_nd;
  logic          error;

  message_stitcher #(
    .N_SLICES      (N),
    .WIDTH         (W),
    .FIFO_DEPTH    (8),
    .LOG_FIFO_DEPTH(3),
    .MIN_GAP       (MIN_GAP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_nd   (in_nd),
    .flush   (flush),
    .out_data(out_data),
    .out_nd  (out_nd),
    .error   (error)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            last_cyc = 0;
  int            ph_tog = 0;
  bit            mon_en = 1'b0;
  bit            exact_gap = 1'b0;
  logic          prev_nd = 1'b0;
  logic [OW-1:0] sb[$];
  logic [OW-1:0] bp = '0;
  int            bcnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Every out_nd level change consumes one expected wide word.
  always @(negedge clk) begin
    if (mon_en && (out_nd !== prev_nd)) begin
      if (sb.size() == 0) chk("spurious_toggle", out_nd, prev_nd);
      else chk("out_data", out_data, sb.pop_front());
      if (exact_gap && ph_tog > 0) chk("toggle_gap", cyc - last_cyc, MIN_GAP);
      prev_nd  = out_nd;
      last_cyc = cyc;
      ph_tog++;
    end
  end

  // Called at a negedge; holds inputs across one posedge and returns at the next negedge.
  task automatic send(input bit nd, input logic [W-1:0] d, input bit fl, input bit drop);
    in_nd   = nd;
    in_data = d;
    flush   = fl;
    if (nd) begin
      bp[(N-1-bcnt)*W +: W] = d;
      bcnt++;
    end
    if (bcnt == N || (fl && bcnt > 0)) begin
      if (!drop) sb.push_back(bp);
      bp   = '0;
      bcnt = 0;
    end
    @(negedge clk);
    in_nd = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int max);
    int k = 0;
    while (sb.size() > 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sb.size(), 0);
    idle(6);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_nd", out_nd, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    bp      = '0;
    bcnt    = 0;
    prev_nd = 1'b0;
    mon_en  = 1'b1;
  endtask

  initial begin
    logic saved;
    do_reset();

    // Basic pair and first-word latency.
    send(1, 32'hA, 0, 0);
    send(1, 32'hB, 0, 0);
    chk("lat_before", out_nd, 0);
    @(negedge clk);
    chk("lat_toggle", out_nd, 1);
    chk("lat_data", out_data, 64'h0000000A_0000000B);
    drain(20);

    // Back-to-back narrow words: toggles exactly MIN_GAP apart.
    exact_gap = 1'b1;
    ph_tog    = 0;
    for (int i = 1; i <= 6; i++) send(1, W'(i), 0, 0);
    drain(30);
    chk("burst_toggles", ph_tog, 3);
    chk("burst_error", error, 0);
    exact_gap = 1'b0;

    // Flush of a partial word, then a flush with nothing pending.
    ph_tog = 0;
    send(1, 32'h7, 0, 0);
    send(0, '0, 1, 0);
    drain(20);
    chk("flush_data", out_data, 64'h00000007_00000000);
    saved = out_nd;
    send(0, '0, 1, 0);
    idle(8);
    chk("flush_noop", out_nd, saved);
    chk("flush_toggles", ph_tog, 1);

    // Flush together with in_nd: completing word pushes once; from count 0 it pushes a partial.
    ph_tog = 0;
    send(1, 32'h11, 0, 0);
    send(1, 32'h22, 1, 0);
    send(1, 32'h33, 1, 0);
    drain(20);
    chk("ndflush_toggles", ph_tog, 2);
    chk("ndflush_data", out_data, 64'h00000033_00000000);

    // One push per cycle against one pop per two cycles: words 16 and 18 find the FIFO full.
    exact_gap = 1'b1;
    ph_tog    = 0;
    for (int c = 0; c < 20; c++) begin
      send(1, 32'h100 + W'(c), 1, (c == 16) || (c == 18));
      if (c == 15) chk("ovf_err_pre", error, 0);
      if (c == 16) chk("ovf_err_set", error, 1);
    end
    drain(80);
    chk("ovf_toggles", ph_tog, 18);
    chk("ovf_err_sticky", error, 1);
    exact_gap = 1'b0;

    // Reset with a partial group and queued words outstanding.
    for (int c = 0; c < 6; c++) send(1, 32'h200 + W'(c), 1, 0);
    send(1, 32'h2FF, 0, 0);
    do_reset();
    ph_tog = 0;
    send(1, 32'h55, 0, 0);
    send(1, 32'h66, 0, 0);
    @(negedge clk);
    chk("post_rst_nd", out_nd, 1);
    chk("post_rst_data", out_data, 64'h00000055_00000066);
    drain(20);
    chk("post_rst_toggles", ph_tog, 1);
    chk("post_rst_err", error, 0);

    // Random sparse stream.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) send(1, $urandom, 0, 0);
      else send(0, '0, 0, 0);
    end
    if (bcnt > 0) send(0, '0, 1, 0);
    drain(200);
    chk("rand_err", error, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
